// File: rtl/codec_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codec_audio_pkg
// Description : Shared types and constants for the codec audio capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_audio_pkg;

    // Sample width used when the instantiating code does not override it
    localparam int DATA_W_DEFAULT = 24;

    // I2S word-select polarity: LRCLK low carries left, high carries right
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Capture sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        WAIT  = 3'd4
    } i2s_cap_state_t;

endpackage : codec_audio_pkg
`default_nettype wire

// File: rtl/codec_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : codec_sync_edge
// Description : Multi-stage synchronizer for one asynchronous input plus a
//               registered copy of the synchronized level, giving level,
//               rising-edge and any-change pulses in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_change
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_q;

    // Synchronizer chain and one-cycle-delayed copy of its output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_q    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_q    <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level  = r_sync[SYNC_STAGES-1];
    assign o_rise   = o_level & ~r_q;
    assign o_change = o_level ^ r_q;

endmodule : codec_sync_edge
`default_nettype wire

// File: rtl/codec_i2s_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : codec_i2s_adc_capture
// Description : Oversamples the codec ADC I2S bus in the system clock domain
//               and deserializes one selected channel into a DATA_W-bit
//               two's-complement word, held stable for the downstream port.
//               Optional macro CODEC_I2S_PEAK_EN adds peak_out, the running
//               maximum magnitude of loaded samples.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_i2s_adc_capture
    import codec_audio_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_adcdat,
    input  logic              chan_sel,
    input  logic              sample_ack,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
`ifdef CODEC_I2S_PEAK_EN
    output logic [DATA_W-2:0] peak_out,
`endif
    output logic              overrun
);

    localparam int                 c_CNT_W    = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------------
    logic w_bclk_rise;
    logic w_lrclk_s;
    logic w_lr_edge;
    logic w_adcdat_s;
    logic w_unused_bclk_level;
    logic w_unused_bclk_change;
    logic w_unused_lr_rise;
    logic w_unused_dat_rise;
    logic w_unused_dat_change;

    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk      (clk),
        .reset    (reset),
        .i_async  (i2s_bclk),
        .o_level  (w_unused_bclk_level),
        .o_rise   (w_bclk_rise),
        .o_change (w_unused_bclk_change)
    );

    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk      (clk),
        .reset    (reset),
        .i_async  (i2s_lrclk),
        .o_level  (w_lrclk_s),
        .o_rise   (w_unused_lr_rise),
        .o_change (w_lr_edge)
    );

    // Data shares the bit clock's synchronizer depth, so it is aligned with
    // w_bclk_rise without further compensation.
    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adcdat (
        .clk      (clk),
        .reset    (reset),
        .i_async  (i2s_adcdat),
        .o_level  (w_adcdat_s),
        .o_rise   (w_unused_dat_rise),
        .o_change (w_unused_dat_change)
    );

    // ------------------------------------------------------------------------
    // Slot sequencer
    // ------------------------------------------------------------------------
    i2s_cap_state_t       r_state;
    i2s_cap_state_t       w_state_nxt;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_CNT_W-1:0]   w_bit_cnt_nxt;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    w_shift_nxt;
    logic                 r_slot_ch;
    logic                 w_slot_ch_nxt;
    logic                 r_slot_sel;
    logic                 w_slot_sel_nxt;
    logic                 w_load;

    // Sequencer state, bit counter, shift register and per-slot latches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_slot_ch  <= CH_LEFT;
            r_slot_sel <= CH_LEFT;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_slot_ch  <= w_slot_ch_nxt;
            r_slot_sel <= w_slot_sel_nxt;
        end
    end

    // Next-state logic; LRCLK moves on falling BCLK, so its change pulse
    // always precedes the rising edge that SKIP consumes as the delay bit.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_slot_ch_nxt  = r_slot_ch;
        w_slot_sel_nxt = r_slot_sel;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_lr_edge) begin
                    w_state_nxt = SKIP;
                end
            end
            SKIP: begin
                if (w_bclk_rise) begin
                    w_slot_ch_nxt  = w_lrclk_s;
                    w_slot_sel_nxt = chan_sel;
                    w_bit_cnt_nxt  = '0;
                    w_state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (w_lr_edge) begin
                    // Slot ended early: drop the partial word
                    w_state_nxt = SKIP;
                end else if (w_bclk_rise) begin
                    w_shift_nxt = {r_shift[DATA_W-2:0], w_adcdat_s};
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                    end
                end
            end
            DONE: begin
                w_load      = (r_slot_ch == r_slot_sel);
                w_state_nxt = w_lr_edge ? SKIP : WAIT;
            end
            WAIT: begin
                if (w_lr_edge) begin
                    w_state_nxt = SKIP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output word and handshake flags
    // ------------------------------------------------------------------------
    logic w_ovr_set;

    // An unacknowledged sample being overwritten is the only overrun source
    assign w_ovr_set = w_load & sample_valid & ~sample_ack;

    // Load wins over ack for valid; overrun set wins over clear
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (w_load) begin
                sample_out <= r_shift;
            end
            sample_valid <= w_load | (sample_valid & ~sample_ack);
            overrun      <= w_ovr_set | (overrun & ~ovr_clr);
        end
    end

`ifdef CODEC_I2S_PEAK_EN
    // ------------------------------------------------------------------------
    // Peak magnitude tracker
    // ------------------------------------------------------------------------
    logic [DATA_W-2:0] w_low;
    logic [DATA_W-2:0] w_neg_low;
    logic [DATA_W-2:0] w_abs;

    // For a negative word, -x = 2^(N-1) - low bits; a zero low part is the
    // most negative value, whose magnitude saturates to all ones.
    assign w_low     = r_shift[DATA_W-2:0];
    assign w_neg_low = (~w_low) + {{(DATA_W-2){1'b0}}, 1'b1};
    assign w_abs     = !r_shift[DATA_W-1] ? w_low :
                       (w_low == '0)      ? {(DATA_W-1){1'b1}} : w_neg_low;

    // Running maximum over loads, restarted by the consumer's ack
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_out <= '0;
        end else if (w_load) begin
            if (sample_ack || (w_abs > peak_out)) begin
                peak_out <= w_abs;
            end
        end else if (sample_ack) begin
            peak_out <= '0;
        end
    end
`endif

endmodule : codec_i2s_adc_capture
`default_nettype wire

// File: tb/tb_codec_i2s_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_codec_i2s_adc_capture
// Description : Self-checking bench for codec_i2s_adc_capture. The I2S bus is
//               driven on clk falling edges with BCLK = clk/8 and 32 BCLK per
//               slot; a vector table covers channel selection, overrun and
//               short slots, followed by hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_i2s_adc_capture;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_adcdat;
    logic          chan_sel;
    logic          sample_ack;
    logic          ovr_clr;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic          overrun;
`ifdef CODEC_I2S_PEAK_EN
    logic [DW-2:0] peak_out;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    codec_i2s_adc_capture #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_adcdat   (i2s_adcdat),
        .chan_sel     (chan_sel),
        .sample_ack   (sample_ack),
        .ovr_clr      (ovr_clr),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
`ifdef CODEC_I2S_PEAK_EN
        .peak_out     (peak_out),
`endif
        .overrun      (overrun)
    );

    typedef struct {
        logic          sel;
        logic          lr;
        logic [DW-1:0] word;
        int            nbits;
        bit            ack_first;
        bit            clr_first;
        bit            lat;
        logic [DW-1:0] exp_out;
        logic          exp_valid;
        logic          exp_ovr;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] e_out, input logic e_valid, input logic e_ovr);
        check({tag, "_out"},   sample_out,   e_out);
        check({tag, "_valid"}, sample_valid, e_valid);
        check({tag, "_ovr"},   overrun,      e_ovr);
    endtask

    task automatic pulse_ack();
        @(negedge clk) sample_ack = 1'b1;
        @(negedge clk) sample_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) ovr_clr = 1'b1;
        @(negedge clk) ovr_clr = 1'b0;
    endtask

    // One slot: a delay bit after the LRCLK change, then nbits bits of which
    // the first DW carry the word MSB first. The LSB's pin rise is followed
    // by the load on the 4th clk posedge, i.e. between negedges 3 and 4.
    task automatic send_slot(input logic lr, input logic [DW-1:0] word, input int nbits,
                             input bit ack_at_load, input bit lat_chk, input int sel_flip_at);
        i2s_bclk   = 1'b0;
        i2s_lrclk  = lr;
        i2s_adcdat = 1'b0;
        repeat (4) @(negedge clk);
        i2s_bclk = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            i2s_bclk = 1'b0;
            if (i < DW) i2s_adcdat = word[DW-1-i];
            else        i2s_adcdat = 1'b0;
            if (i == sel_flip_at) chan_sel = ~chan_sel;
            repeat (4) @(negedge clk);
            i2s_bclk = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == DW-1 && k == 3) begin
                    if (ack_at_load) sample_ack = 1'b1;
                    if (lat_chk) check("latency_before_load_valid", sample_valid, 1'b0);
                end
                if (i == DW-1 && k == 4) begin
                    sample_ack = 1'b0;
                    if (lat_chk) begin
                        check("latency_at_load_valid", sample_valid, 1'b1);
                        check("latency_at_load_out", sample_out, word);
                    end
                end
            end
        end
    endtask

    initial begin
        //            sel   lr    word       nb  ack   clr   lat   exp_out    v     ovr
        vt[0] = '{1'b0, 1'b1, 24'h000000, 31, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 24'h800001, 31, 1'b0, 1'b0, 1'b1, 24'h800001, 1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b1, 24'hABCDEF, 31, 1'b1, 1'b0, 1'b0, 24'hABCDEF, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b0, 24'h123456, 31, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 24'h654321, 31, 1'b0, 1'b0, 1'b0, 24'h654321, 1'b1, 1'b1};
        vt[5] = '{1'b1, 1'b0, 24'h777777, 31, 1'b0, 1'b1, 1'b0, 24'h654321, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 24'h222222, 31, 1'b1, 1'b0, 1'b0, 24'h654321, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 24'hFFFFFF, 10, 1'b0, 1'b0, 1'b0, 24'h654321, 1'b0, 1'b0};
        vt[8] = '{1'b1, 1'b1, 24'h0F0F0F, 31, 1'b0, 1'b0, 1'b0, 24'h0F0F0F, 1'b1, 1'b0};
        vt[9] = '{1'b1, 1'b0, 24'h000000, 31, 1'b0, 1'b0, 1'b0, 24'h0F0F0F, 1'b1, 1'b0};

        reset      = 1'b1;
        i2s_bclk   = 1'b0;
        i2s_lrclk  = 1'b0;
        i2s_adcdat = 1'b0;
        chan_sel   = 1'b0;
        sample_ack = 1'b0;
        ovr_clr    = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_all("reset", 24'h0, 1'b0, 1'b0);
`ifdef CODEC_I2S_PEAK_EN
        check("reset_peak", {1'b0, peak_out}, 24'h0);
`endif

        for (int i = 0; i < 10; i++) begin
            chan_sel = vt[i].sel;
            if (vt[i].ack_first) pulse_ack();
            if (vt[i].clr_first) pulse_clr();
            send_slot(vt[i].lr, vt[i].word, vt[i].nbits, 1'b0, vt[i].lat, -1);
            check_all($sformatf("v%0d", i), vt[i].exp_out, vt[i].exp_valid, vt[i].exp_ovr);
        end

        // Ack landing on the very load cycle: the load wins, no overrun
        send_slot(1'b1, 24'h13579B, 31, 1'b1, 1'b0, -1);
        check_all("ack_at_load", 24'h13579B, 1'b1, 1'b0);

        // chan_sel flipped mid-slot only affects the following slot
        pulse_ack();
        chan_sel = 1'b0;
        send_slot(1'b0, 24'h00ABCD, 31, 1'b0, 1'b0, 5);
        check_all("sel_mid_slot", 24'h00ABCD, 1'b1, 1'b0);
        send_slot(1'b1, 24'h112233, 31, 1'b0, 1'b0, -1);
        check_all("sel_next_slot", 24'h112233, 1'b1, 1'b1);
        pulse_clr();
        check("ovr_clr", overrun, 1'b0);

        // Reset in the middle of SHIFT, then resume only after a fresh lr edge
        send_slot(1'b0, 24'hFFFFFF, 12, 1'b0, 1'b0, -1);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all("mid_reset", 24'h0, 1'b0, 1'b0);
`ifdef CODEC_I2S_PEAK_EN
        check("mid_reset_peak", {1'b0, peak_out}, 24'h0);
`endif
        chan_sel = 1'b1;
        send_slot(1'b0, 24'hFFFFFF, 20, 1'b0, 1'b0, -1);
        check_all("after_reset_no_edge", 24'h0, 1'b0, 1'b0);
        send_slot(1'b1, 24'h2468AC, 31, 1'b0, 1'b0, -1);
        check_all("after_reset_resume", 24'h2468AC, 1'b1, 1'b0);

`ifdef CODEC_I2S_PEAK_EN
        pulse_ack();
        check("peak_ack_clear", {1'b0, peak_out}, 24'h0);
        send_slot(1'b0, 24'h000000, 31, 1'b0, 1'b0, -1);
        send_slot(1'b1, 24'h000100, 31, 1'b0, 1'b0, -1);
        check("peak_1", {1'b0, peak_out}, 24'h000100);
        send_slot(1'b0, 24'h000000, 31, 1'b0, 1'b0, -1);
        send_slot(1'b1, 24'hFFF000, 31, 1'b0, 1'b0, -1);
        check("peak_2", {1'b0, peak_out}, 24'h001000);
        send_slot(1'b0, 24'h000000, 31, 1'b0, 1'b0, -1);
        send_slot(1'b1, 24'h800000, 31, 1'b0, 1'b0, -1);
        check("peak_3", {1'b0, peak_out}, 24'h7FFFFF);
        pulse_ack();
        check("peak_4", {1'b0, peak_out}, 24'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_codec_i2s_adc_capture
`default_nettype wire
